// File: rtl/div.sv
// div: sequential 32-bit signed non-restoring divider, one quotient bit per cycle, truncating quotient.
module div (
  input  logic        clock,
  input  logic        dataReset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] result,
  output logic        exception,
  output logic        resultReady,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state, state_n;
  logic [32:0] a, a_sh, a_nx;
  logic [31:0] q, m;
  logic        neg, dz;
  logic [5:0]  cnt;
  always_comb begin
    state_n = start ? RUN :
              state == RUN ? (cnt == 6'd32 ? FIX : RUN) :
              state == FIX ? DONE : IDLE;
    busy = (state == RUN) || (state == FIX);
    a_sh = {a[31:0], q[31]};
    a_nx = a[32] ? a_sh + {1'b0, m} : a_sh - {1'b0, m};
  end
  // A start in any state (including RUN/FIX) reloads, silently abandoning the old operation
  always_ff @(posedge clock) begin
    if (dataReset) begin
      state       <= IDLE;
      result      <= '0;
      exception   <= 1'b0;
      resultReady <= 1'b0;
      cnt         <= '0;
      a           <= '0;
      q           <= '0;
      m           <= '0;
      neg         <= 1'b0;
      dz          <= 1'b0;
    end else begin
      state       <= state_n;
      resultReady <= 1'b0;
      if (start) begin
        q   <= dividend[31] ? -dividend : dividend;
        m   <= divisor[31] ? -divisor : divisor;
        a   <= '0;
        neg <= dividend[31] ^ divisor[31];
        dz  <= divisor == '0;
        cnt <= '0;
      end else if (state == RUN && cnt != 6'd32) begin
        a   <= a_nx;
        q   <= {q[30:0], ~a_nx[32]};
        cnt <= cnt + 6'd1;
      end else if (state == FIX) begin
        result      <= dz ? '0 : (neg ? -q : q);
        exception   <= dz;
        resultReady <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_div.sv
// tb_div: randomized self-checking bench for div against a plain-arithmetic reference.
module tb_div;
  logic        clock = 1'b0;
  logic        dataReset, start;
  logic [31:0] dividend, divisor, result;
  logic        exception, resultReady, busy;
  int          errors = 0, checks = 0;

  div dut (
    .clock(clock), .dataReset(dataReset), .start(start),
    .dividend(dividend), .divisor(divisor),
    .result(result), .exception(exception),
    .resultReady(resultReady), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    if (y == 0) return 32'h0;
    if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
    return 32'($signed(x) / $signed(y));
  endfunction

  task automatic go(input logic [31:0] x, input logic [31:0] y);
    dividend = x;
    divisor  = y;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic wait_rdy(output int n);
    n = 0;
    do begin
      @(posedge clock);
      #1;
      n++;
    end while (!resultReady && n < 40);
  endtask

  task automatic run(input string tag, input logic [31:0] x, input logic [31:0] y, input bit pulse_chk);
    int n;
    logic [31:0] prev;
    prev = result;
    go(x, y);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_hold"}, result, prev);
    wait_rdy(n);
    chk({tag, "_lat"}, 32'(n), 32'd34);
    chk({tag, "_res"}, result, ref_div(x, y));
    chk({tag, "_exc"}, 32'(exception), 32'(y == 0));
    if (pulse_chk) begin
      chk({tag, "_busy_done"}, 32'(busy), 32'd0);
      @(posedge clock);
      #1;
      chk({tag, "_pulse"}, 32'(resultReady), 32'd0);
      chk({tag, "_keep"}, result, ref_div(x, y));
    end
  endtask

  initial begin
    int n, pulses;
    logic [31:0] x, y;
    dataReset = 1'b1;
    start     = 1'b1;
    dividend  = 32'd5;
    divisor   = 32'd1;
    repeat (2) @(posedge clock);
    #1;
    start = 1'b0;
    chk("rst_res", result, 32'h0);
    chk("rst_exc", 32'(exception), 32'd0);
    chk("rst_rdy", 32'(resultReady), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    dataReset = 1'b0;
    @(posedge clock);
    #1;
    chk("idle_busy", 32'(busy), 32'd0);

    run("d100_7", 32'd100, 32'd7, 1);
    run("dm100_7", -32'sd100, 32'd7, 1);
    run("d100_m7", 32'd100, -32'sd7, 1);
    run("dm100_m7", -32'sd100, -32'sd7, 1);
    run("d7_100", 32'd7, 32'd100, 1);
    run("dm7_100", -32'sd7, 32'd100, 1);
    run("dz", 32'd12345, 32'd0, 1);
    run("d9_3", 32'd9, 32'd3, 1);
    run("ovf", 32'h80000000, 32'hFFFFFFFF, 1);
    run("min_2", 32'h80000000, 32'd2, 1);
    run("min_min", 32'h80000000, 32'h80000000, 1);
    run("big_min", 32'h7FFFFFFF, 32'h80000000, 1);

    // abort in RUN
    go(32'd1000, 32'd10);
    repeat (10) @(posedge clock);
    #1;
    go(32'd50, 32'd5);
    wait_rdy(n);
    chk("abort_run_lat", 32'(n), 32'd34);
    chk("abort_run_res", result, 32'd10);
    @(posedge clock);
    #1;

    // abort while in FIX: result must not change and no pulse for the aborted op
    go(32'd77, 32'd7);
    repeat (33) @(posedge clock);
    #1;
    chk("abort_fix_busy", 32'(busy), 32'd1);
    go(32'd90, 32'd9);
    chk("abort_fix_hold", result, 32'd10);
    wait_rdy(n);
    chk("abort_fix_lat", 32'(n), 32'd34);
    chk("abort_fix_res", result, 32'd10);
    @(posedge clock);
    #1;

    // back-to-back: start during the ready cycle
    go(32'd21, 32'd3);
    wait_rdy(n);
    chk("b2b_first", result, 32'd7);
    go(32'd64, -32'sd4);
    wait_rdy(n);
    chk("b2b_lat", 32'(n + 1), 32'd35);
    chk("b2b_res", result, 32'hFFFFFFF0);
    @(posedge clock);
    #1;

    // reset mid-RUN
    go(32'd1000, 32'd10);
    repeat (10) @(posedge clock);
    #1;
    dataReset = 1'b1;
    @(posedge clock);
    #1;
    dataReset = 1'b0;
    chk("mrst_res", result, 32'h0);
    chk("mrst_exc", 32'(exception), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    pulses = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      pulses += int'(resultReady);
    end
    chk("mrst_nopulse", 32'(pulses), 32'd0);

    for (int i = 0; i < 1000; i++) begin
      x = $urandom >> $urandom_range(0, 31);
      y = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) x = -x;
      if ($urandom_range(0, 1) == 1) y = -y;
      if (y == 0) y = 32'd1;
      if (x == 32'h80000000 && y == 32'hFFFFFFFF) x = 32'd0;
      run("rnd", x, y, i % 2 == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
